// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

  localparam int unsigned XLEN_D    = 32;
  localparam int unsigned NREG_D    = 32;
  localparam int unsigned ZERO_ADDR = 0;

  // Minimum address width for n registers (at least one bit).
  function automatic int unsigned addr_width(int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w++;
    return w;
  endfunction

  // Register index is architecturally writable/trackable.
  function automatic logic reg_valid(int unsigned addr, int unsigned nreg, bit zero_reg);
    return (addr < nreg) && !(zero_reg && (addr == ZERO_ADDR));
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/issue bundle between decode-issue logic (master) and the register file (slave).
interface regfile_mp_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 2
);
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic                sb_flush;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr, sb_flush,
    input  rd_data, rd_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_addr, sb_flush,
    output rd_data, rd_busy
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one pending bit per register plus per-read-port busy lookup.
// REGFILE_MP_BYPASS_EN: a same-cycle retiring write masks the busy flag of a matching reader.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREG     = NREG_D,
  parameter int unsigned AW       = addr_width(NREG),
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD-1:0]    rd_busy_c
);
  localparam bit ZR = (ZERO_REG != 0);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Retire first, then issue, so a same-cycle newer producer stays outstanding.
  always_comb begin : pending_next
    logic [AW-1:0] wa;
    wa        = '0;
    pending_d = pending_q;
    for (int j = 0; j < NWR; j++) begin
      wa = wr_addr[j*AW +: AW];
      if (wr_en[j] && reg_valid(32'(wa), NREG, ZR)) pending_d[wa] = 1'b0;
    end
    if (iss_valid && reg_valid(32'(iss_addr), NREG, ZR)) pending_d[iss_addr] = 1'b1;
    if (flush) pending_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending_q <= '0;
    else     pending_q <= pending_d;
  end

  always_comb begin : busy_lookup
    logic [AW-1:0] ra;
    ra        = '0;
    rd_busy_c = '0;
    for (int k = 0; k < NRD; k++) begin
      ra = rd_addr[k*AW +: AW];
      if (reg_valid(32'(ra), NREG, ZR)) rd_busy_c[k] = pending_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == ra)) rd_busy_c[k] = 1'b0;
      end
`endif
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with combinational reads and an integrated pending-write scoreboard.
// REGFILE_MP_BYPASS_EN: forwards same-cycle write data to matching read ports.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_D,
  parameter int unsigned NREG     = NREG_D,
  parameter int unsigned AW       = addr_width(NREG),
  parameter int unsigned NRD      = 2,
  parameter int unsigned NWR      = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam bit ZR = (ZERO_REG != 0);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NRD-1:0]  busy_c;

  // Ascending port order lets the highest-index port win on address collisions.
  always_comb begin : write_merge
    logic [AW-1:0] wa;
    wa     = '0;
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      wa = bus.wr_addr[j*AW +: AW];
      if (bus.wr_en[j] && reg_valid(32'(wa), NREG, ZR)) regs_d[wa] = bus.wr_data[j*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin : read_mux
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;
    ra          = '0;
    val         = '0;
    bus.rd_data = '0;
    for (int k = 0; k < NRD; k++) begin
      ra  = bus.rd_addr[k*AW +: AW];
      val = '0;
      if (reg_valid(32'(ra), NREG, ZR)) begin
        val = regs_q[ra];
`ifdef REGFILE_MP_BYPASS_EN
        for (int j = 0; j < NWR; j++) begin
          if (bus.wr_en[j] && (bus.wr_addr[j*AW +: AW] == ra)) val = bus.wr_data[j*XLEN +: XLEN];
        end
`endif
      end
      bus.rd_data[k*XLEN +: XLEN] = val;
    end
  end

  regfile_scoreboard #(
    .NREG     (NREG),
    .AW       (AW),
    .NRD      (NRD),
    .NWR      (NWR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (bus.wr_en),
    .wr_addr   (bus.wr_addr),
    .iss_valid (bus.iss_valid),
    .iss_addr  (bus.iss_addr),
    .flush     (bus.sb_flush),
    .rd_addr   (bus.rd_addr),
    .rd_busy_c (busy_c)
  );

  assign bus.rd_busy = busy_c;

endmodule
